// File: rtl/pn_dispatch_ctrl.sv
// pn_dispatch_ctrl: FIFO-buffered host/SWU event dispatcher with split two-neuron spike reads; PN_DISPATCH_PERF_EN adds perf counters.
module pn_dispatch_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int NADDR_W    = 7,
  parameter int SWU_DATA_W = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kill,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [DATA_W-1:0]     host_data,
  input  logic                  swu_valid,
  output logic                  swu_ready,
  input  logic [NADDR_W-1:0]    swu_addr,
  input  logic [SWU_DATA_W-1:0] swu_data,
  output logic                  syn_we,
  output logic                  syn_re,
  output logic                  syn_rc,
  output logic [NADDR_W-1:0]    syn_addr,
  output logic [DATA_W-1:0]     syn_data,
  output logic                  soma_we,
  output logic [DATA_W-1:0]     soma_data,
  output logic                  stdp_we,
  output logic [NADDR_W-1:0]    stdp_addr,
  output logic [DATA_W-1:0]     stdp_data,
  output logic                  busy
`ifdef PN_DISPATCH_PERF_EN
  ,
  output logic [31:0]           perf_spike_cnt,
  output logic [31:0]           perf_param_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_W + DATA_W;
  typedef enum logic [1:0] {IDLE, ISSUE, SPLIT2} state_t;
  state_t state, state_nxt;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic full, empty, push, pop, sec;
  logic [ADDR_W-1:0] swu_word, in_addr, head_addr;
  logic [DATA_W-1:0] in_data, head_data, sec_data;
  logic [NADDR_W-1:0] na, field, sec_addr;
  logic [1:0] sel;
  logic param, rich, d_we, d_re, d_rc, d_soma, d_stdp, d_split, split_pend;
  logic n_we, n_re, n_rc, n_soma, n_stdp, n_syn;
  assign full = count == (PW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign host_ready = !full && !swu_valid;
  assign swu_ready = !full;
  assign push = !kill && !full && (swu_valid || host_valid);
  assign busy = !empty || (state == ISSUE && split_pend);
  always_comb begin
    swu_word = '0;
    swu_word[ADDR_W-1] = 1'b1;
    swu_word[13:12] = 2'b01;
    swu_word[NADDR_W-1:0] = swu_addr;
  end
  assign in_addr = swu_valid ? swu_word : host_addr;
  assign in_data = swu_valid ? DATA_W'(swu_data) : host_data;
  assign {head_addr, head_data} = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_addr, in_data};
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // Head-of-FIFO decode, registered into the strobe outputs on pop
  assign param = head_addr[ADDR_W-1];
  assign rich = head_addr[ADDR_W-2];
  assign sel = head_addr[13:12];
  assign na = head_addr[NADDR_W-1:0];
  assign field = head_addr[2*NADDR_W-1:NADDR_W];
  assign d_we = param && !sel[1];
  assign d_re = !param;
  assign d_rc = param ? sel == 2'b00 : rich;
  assign d_soma = param && sel == 2'b10;
  assign d_stdp = param && sel == 2'b11;
  assign d_split = !param && !rich && field != '0;
  always_comb begin
    sec = !kill && state == ISSUE && split_pend;
    pop = !kill && !empty && !(state == ISSUE && split_pend);
    state_nxt = kill ? IDLE : sec ? SPLIT2 : pop ? ISSUE : IDLE;
    n_we = pop && d_we;
    n_re = (pop && d_re) || sec;
    n_rc = pop && d_rc;
    n_soma = pop && d_soma;
    n_stdp = pop && d_stdp;
    n_syn = pop && (d_we || d_re);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      split_pend <= 1'b0;
      sec_addr <= '0;
      sec_data <= '0;
      {syn_we, syn_re, syn_rc, soma_we, stdp_we} <= '0;
      {syn_addr, syn_data, soma_data, stdp_addr, stdp_data} <= '0;
    end else begin
      state <= state_nxt;
      split_pend <= pop && d_split;
      sec_addr <= field;
      sec_data <= head_data;
      {syn_we, syn_re, syn_rc, soma_we, stdp_we} <= {n_we, n_re, n_rc, n_soma, n_stdp};
      syn_addr <= sec ? sec_addr : n_syn ? na : '0;
      syn_data <= sec ? sec_data : n_syn ? head_data : '0;
      soma_data <= n_soma ? head_data : '0;
      stdp_addr <= n_stdp ? na : '0;
      stdp_data <= n_stdp ? head_data : '0;
    end
  end
`ifdef PN_DISPATCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_spike_cnt <= '0;
      perf_param_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_spike_cnt <= perf_spike_cnt + 32'(syn_re && !(&perf_spike_cnt));
      perf_param_cnt <= perf_param_cnt + 32'((syn_we || soma_we || stdp_we) && !(&perf_param_cnt));
      perf_stall_cnt <= perf_stall_cnt + 32'(host_valid && !host_ready && !(&perf_stall_cnt));
    end
  end
`endif
endmodule

// File: tb/tb_pn_dispatch_ctrl.sv
// tb_pn_dispatch_ctrl: vector table, corner sequences and randomized stream against a strobe-queue model.
module tb_pn_dispatch_ctrl;
  logic clk = 1'b0;
  logic rst, kill, host_valid, host_ready, swu_valid, swu_ready;
  logic [15:0] host_addr;
  logic [31:0] host_data;
  logic [6:0] swu_addr;
  logic [7:0] swu_data;
  logic syn_we, syn_re, syn_rc, soma_we, stdp_we, busy;
  logic [6:0] syn_addr, stdp_addr;
  logic [31:0] syn_data, soma_data, stdp_data;
  typedef logic [114:0] ov_t;
  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    ov_t e1;
    ov_t e2;
  } vec_t;
  vec_t tv[8];
  ov_t exp_q[$];
  ov_t mon_o;
  int checks = 0;
  int failures = 0;
  bit mon_en = 0;
  bit saw_full = 0;
  always #5 clk = ~clk;
  pn_dispatch_ctrl #(.ADDR_W(16), .DATA_W(32), .NADDR_W(7), .SWU_DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .kill(kill),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr), .host_data(host_data),
    .swu_valid(swu_valid), .swu_ready(swu_ready), .swu_addr(swu_addr), .swu_data(swu_data),
    .syn_we(syn_we), .syn_re(syn_re), .syn_rc(syn_rc), .syn_addr(syn_addr), .syn_data(syn_data),
    .soma_we(soma_we), .soma_data(soma_data),
    .stdp_we(stdp_we), .stdp_addr(stdp_addr), .stdp_data(stdp_data), .busy(busy)
  );
  // Kinds: 1 synapse write, 2 synapse read, 3 soma write, 4 stdp write
  function automatic ov_t mk(int k, bit rc, logic [6:0] a, logic [31:0] d);
    ov_t v = '0;
    if (k == 1) v = {1'b1, 1'b0, rc, a, d, 1'b0, 32'h0, 1'b0, 7'h0, 32'h0};
    else if (k == 2) v = {1'b0, 1'b1, rc, a, d, 1'b0, 32'h0, 1'b0, 7'h0, 32'h0};
    else if (k == 3) v = {3'b0, 7'h0, 32'h0, 1'b1, d, 1'b0, 7'h0, 32'h0};
    else if (k == 4) v = {3'b0, 7'h0, 32'h0, 1'b0, 32'h0, 1'b1, a, d};
    return v;
  endfunction
  function automatic ov_t obs();
    return {syn_we, syn_re, syn_rc, syn_addr, syn_data, soma_we, soma_data, stdp_we, stdp_addr, stdp_data};
  endfunction
  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Reference: the strobes an accepted entry must produce, in order
  function automatic void model(logic [15:0] a, logic [31:0] d);
    if (a[15]) begin
      if (a[13:12] == 2'b00) exp_q.push_back(mk(1, 1, a[6:0], d));
      else if (a[13:12] == 2'b01) exp_q.push_back(mk(1, 0, a[6:0], d));
      else if (a[13:12] == 2'b10) exp_q.push_back(mk(3, 0, 7'h0, d));
      else exp_q.push_back(mk(4, 0, a[6:0], d));
    end else if (a[14]) exp_q.push_back(mk(2, 1, a[6:0], d));
    else begin
      exp_q.push_back(mk(2, 0, a[6:0], d));
      if (a[13:7] != 7'h0) exp_q.push_back(mk(2, 0, a[13:7], d));
    end
  endfunction
  always @(negedge clk) if (mon_en) begin
    mon_o = obs();
    if (syn_we || syn_re || soma_we || stdp_we) begin
      if (exp_q.size() == 0) check("unexpected_strobe", mon_o, '0);
      else begin
        check("stream", mon_o, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end else check("idle_zero", mon_o, '0);
    check("ready_rel", host_ready, swu_ready && !swu_valid);
    if (!swu_ready) saw_full = 1;
    if (kill) exp_q.delete();
    else if (swu_valid && swu_ready) model({4'b1001, 5'b0, swu_addr}, {24'h0, swu_data});
    else if (host_valid && host_ready) model(host_addr, host_data);
  end
  task automatic push_host(logic [15:0] a, logic [31:0] d);
    int n = 0;
    host_valid = 1; host_addr = a; host_data = d;
    @(negedge clk);
    while (!host_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!host_ready) check("push_timeout", host_ready, 1);
    @(posedge clk); #1;
    host_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    rst = 1; kill = 0; host_valid = 0; host_addr = 0; host_data = 0;
    swu_valid = 0; swu_addr = 0; swu_data = 0;
    tv[0] = '{16'h9005, 32'hDEADBEEF, mk(1, 0, 7'd5, 32'hDEADBEEF), '0};
    tv[1] = '{16'h8012, 32'h55, mk(1, 1, 7'h12, 32'h55), '0};
    tv[2] = '{16'h0183, 32'h77, mk(2, 0, 7'd3, 32'h77), mk(2, 0, 7'd3, 32'h77)};
    tv[3] = '{16'h0003, 32'h66, mk(2, 0, 7'd3, 32'h66), '0};
    tv[4] = '{16'h4183, 32'h44, mk(2, 1, 7'd3, 32'h44), '0};
    tv[5] = '{16'hA000, 32'h11, mk(3, 0, 7'd0, 32'h11), '0};
    tv[6] = '{16'hB007, 32'h22, mk(4, 0, 7'd7, 32'h22), '0};
    tv[7] = '{16'h0285, 32'h99, mk(2, 0, 7'd5, 32'h99), mk(2, 0, 7'd5, 32'h99)};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_outputs", obs(), '0);
    check("reset_ready", {host_ready, swu_ready, busy}, 3'b110);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      host_valid = 1; host_addr = tv[i].a; host_data = tv[i].d;
      @(posedge clk); #1;
      host_valid = 0;
      @(negedge clk);
      check($sformatf("vec%0d_n1", i), obs(), '0);
      check($sformatf("vec%0d_busy", i), busy, 1);
      @(negedge clk);
      check($sformatf("vec%0d_n2", i), obs(), tv[i].e1);
      @(negedge clk);
      check($sformatf("vec%0d_n3", i), obs(), tv[i].e2);
      repeat (2) @(posedge clk);
    end
    @(posedge clk); #1;
    swu_valid = 1; swu_addr = 7'h12; swu_data = 8'hAB;
    host_valid = 1; host_addr = 16'h9005; host_data = 32'hDEADBEEF;
    @(negedge clk);
    check("swu_prio_host_ready", host_ready, 0);
    check("swu_prio_swu_ready", swu_ready, 1);
    @(posedge clk); #1;
    swu_valid = 0;
    @(negedge clk);
    check("host_after_swu_ready", host_ready, 1);
    @(posedge clk); #1;
    host_valid = 0;
    @(negedge clk);
    check("swu_first", obs(), mk(1, 0, 7'h12, 32'hAB));
    @(negedge clk);
    check("host_second", obs(), mk(1, 0, 7'd5, 32'hDEADBEEF));
    repeat (2) @(posedge clk); #1;
    host_valid = 1; host_addr = 16'hA000; host_data = 32'h11;
    @(posedge clk); #1;
    host_addr = 16'hB007; host_data = 32'h22;
    @(posedge clk); #1;
    host_valid = 0;
    @(negedge clk);
    check("soma_b2b", obs(), mk(3, 0, 7'd0, 32'h11));
    @(negedge clk);
    check("stdp_b2b", obs(), mk(4, 0, 7'd7, 32'h22));
    @(negedge clk);
    check("after_b2b", obs(), '0);
    @(posedge clk); #1;
    host_valid = 1; host_addr = 16'h0285; host_data = 32'h99;
    @(posedge clk); #1;
    host_valid = 0;
    @(posedge clk); #1;
    kill = 1;
    @(negedge clk);
    check("kill_first_read", obs(), mk(2, 0, 7'd5, 32'h99));
    @(posedge clk); #1;
    kill = 0;
    @(negedge clk);
    check("kill_no_second", obs(), '0);
    check("kill_busy", busy, 0);
    @(negedge clk);
    check("kill_still_idle", obs(), '0);
    @(posedge clk); #1;
    host_valid = 1; host_addr = 16'h9001; host_data = 32'h5; kill = 1;
    @(posedge clk); #1;
    host_valid = 0; kill = 0;
    @(negedge clk);
    check("kill_push_busy", busy, 0);
    @(negedge clk);
    check("kill_push_n2", obs(), '0);
    @(negedge clk);
    check("kill_push_n3", obs(), '0);
    @(posedge clk); #1;
    mon_en = 1;
    for (int i = 0; i < 8; i++) push_host({2'b00, 7'(i + 1), 7'(i + 2)}, 32'h100 + 32'(i));
    check("full_seen", saw_full, 1);
    drain();
    for (int i = 0; i < 800; i++) begin
      host_valid = 1'($urandom);
      host_addr = 16'($urandom);
      host_data = $urandom;
      swu_valid = ($urandom_range(5) == 0);
      swu_addr = 7'($urandom);
      swu_data = 8'($urandom);
      kill = ($urandom_range(60) == 0);
      @(posedge clk); #1;
    end
    host_valid = 0; swu_valid = 0; kill = 0;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
